// File: rtl/dram_bank_pkg.sv
// Shared defaults and access-direction encoding for the single-bank DRAM storage model.
package dram_bank_pkg;
  localparam int DEVICE_WIDTH_DEF = 4;
  localparam int COLWIDTH_DEF     = 10;
  localparam int CHWIDTH_DEF      = 5;

  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } access_e;
endpackage

// File: rtl/dram_bank_array.sv
// Single-port synchronous RAM, read-first, no reset so it maps onto block RAM.
// One access per clock, read data registered (1 cycle), no backpressure.
module dram_bank_array #(
  parameter int DW = 4,
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/dram_bank.sv
// One DRAM bank: {row,column} addressed cell array, dqout registered 1 cycle after a read, no backpressure.
// Optional DRAM_BANK_WR_THROUGH_EN echoes write data onto dqout; otherwise dqout holds through writes.
module dram_bank
  import dram_bank_pkg::*;
#(
  parameter int DEVICE_WIDTH = DEVICE_WIDTH_DEF,
  parameter int COLWIDTH     = COLWIDTH_DEF,
  parameter int CHWIDTH      = CHWIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rd_o_wr,
  input  logic [DEVICE_WIDTH-1:0] dqin,
  output logic [DEVICE_WIDTH-1:0] dqout,
  input  logic [CHWIDTH-1:0]      row,
  input  logic [COLWIDTH-1:0]     column
);
  localparam int AW = CHWIDTH + COLWIDTH;

  access_e                 acc;
  logic                    we;
  logic [AW-1:0]           addr;
  logic [DEVICE_WIDTH-1:0] rdata;
  logic [DEVICE_WIDTH-1:0] hold_q;
  logic [DEVICE_WIDTH-1:0] wr_hold;
  logic                    rd_vld_q;

  assign acc  = access_e'(rd_o_wr);
  assign addr = {row, column};
  // The async reset level is what the edge sees, so writes landing during reset are dropped.
  assign we   = (acc == ACC_WRITE) && !reset;

  dram_bank_array #(
    .DW (DEVICE_WIDTH),
    .AW (AW)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .addr  (addr),
    .wdata (dqin),
    .rdata (rdata)
  );

`ifdef DRAM_BANK_WR_THROUGH_EN
  assign wr_hold = dqin;
`else
  assign wr_hold = dqout;
`endif

  // rd_vld_q selects the RAM output after a read edge; hold_q covers writes and post-reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_q <= 1'b0;
      hold_q   <= '0;
    end else if (acc == ACC_WRITE) begin
      rd_vld_q <= 1'b0;
      hold_q   <= wr_hold;
    end else begin
      rd_vld_q <= 1'b1;
    end
  end

  assign dqout = reset ? '0 : (rd_vld_q ? rdata : hold_q);
endmodule

// File: tb/tb_dram_bank.sv
// Directed plus randomized bench for dram_bank against an associative-array memory model.
module tb_dram_bank;
  logic       clk;
  logic       reset;
  logic       rd_o_wr;
  logic [3:0] dqin;
  logic [3:0] dqout;
  logic [4:0] row;
  logic [9:0] column;

  int total = 0;
  int bad   = 0;

  logic [3:0] model [int];
  logic [3:0] exp_dq;
  bit         exp_known;

  dram_bank dut (
    .clk     (clk),
    .reset   (reset),
    .rd_o_wr (rd_o_wr),
    .dqin    (dqin),
    .dqout   (dqout),
    .row     (row),
    .column  (column)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag);
    total++;
    assert (dqout === exp_dq) else begin
      bad++;
      $error("FAIL %s dqout=%h expected=%h", tag, dqout, exp_dq);
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic step(input bit wr, input int r, input int c, input logic [3:0] d, input string tag);
    int key;
    rd_o_wr = wr;
    row     = r[4:0];
    column  = c[9:0];
    dqin    = d;
    key     = r * 1024 + c;
    @(posedge clk);
    #1;
    if (reset) begin
      exp_dq    = 4'h0;
      exp_known = 1'b1;
    end else if (wr) begin
      model[key] = d;
`ifdef DRAM_BANK_WR_THROUGH_EN
      exp_dq    = d;
      exp_known = 1'b1;
`endif
    end else if (model.exists(key)) begin
      exp_dq    = model[key];
      exp_known = 1'b1;
    end else begin
      exp_known = 1'b0;
    end
    if (exp_known) check(tag);
  endtask

  initial begin
    logic [3:0] burst [8];
    int pr [16];
    int pc [16];
    int k;

    burst[0] = 4'h4; burst[1] = 4'h1; burst[2] = 4'h9; burst[3] = 4'h3;
    burst[4] = 4'hD; burst[5] = 4'hD; burst[6] = 4'h5; burst[7] = 4'h2;

    reset = 1'b1; rd_o_wr = 1'b0; dqin = 4'h0; row = '0; column = '0;
    exp_dq = 4'h0; exp_known = 1'b1;
    #1 check("reset_state");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset: preload (0,0), then async reset mid-cycle while writes are attempted.
    step(1, 0, 0, 4'h7, "pre_wr00");
    step(0, 0, 0, 4'h0, "pre_rd00");
    #3 reset = 1'b1;
    #1 exp_dq = 4'h0; check("async_reset_immediate");
    step(1, 0, 0, 4'hC, "wr_in_reset_a");
    step(1, 0, 0, 4'hC, "wr_in_reset_b");
    #2 reset = 1'b0;
    step(0, 0, 0, 4'h0, "rd00_after_reset");

    // Burst write then read, row 1 cols 0..7.
    for (int i = 0; i < 8; i++) step(1, 1, i, burst[i], "burst_wr_hold");
    for (int i = 0; i < 8; i++) step(0, 1, i, 4'h0, "burst_rd");

    // Row isolation.
    step(1, 1, 3, 4'hA, "iso_wr1");
    step(1, 2, 3, 4'h5, "iso_wr2");
    step(0, 1, 3, 4'h0, "iso_rd1");
    step(0, 2, 3, 4'h5, "iso_rd2");

    // Address extremes.
    step(1, 31, 1023, 4'hF, "ext_wr_hi");
    step(1, 0, 0, 4'h1, "ext_wr_lo");
    step(0, 31, 1023, 4'h0, "ext_rd_hi");
    step(0, 0, 0, 4'h0, "ext_rd_lo");

    // Back-to-back write then read of the same cell.
    step(1, 4, 9, 4'h6, "b2b_wr");
    step(0, 4, 9, 4'h0, "b2b_rd");

    // Reset during the 4th of 8 writes; col 3 preloaded so suppression is visible.
    step(1, 6, 3, 4'hE, "mb_preload");
    for (int i = 0; i < 3; i++) step(1, 6, i, burst[i], "mb_wr");
    #2 reset = 1'b1;
    #1 exp_dq = 4'h0; check("mb_async_reset");
    step(1, 6, 3, burst[3], "mb_wr_suppressed");
    #2 reset = 1'b0;
    for (int i = 4; i < 8; i++) step(1, 6, i, burst[i], "mb_wr_rest");
    for (int i = 0; i < 4; i++) step(0, 6, i, 4'h0, "mb_rd");

    // Randomized mix over an address pool, every cell prefilled first.
    pr[0] = 31; pc[0] = 1023;
    for (int i = 1; i < 16; i++) begin
      pr[i] = int'($urandom_range(0, 31));
      pc[i] = int'($urandom_range(0, 1023));
    end
    for (int i = 0; i < 16; i++) step(1, pr[i], pc[i], 4'($urandom), "rnd_fill");
    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 15));
      step(1'($urandom), pr[k], pc[k], 4'($urandom), "rnd_mix");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
